// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: W stage has fixed priority, mul/div results queue in a
// 2-entry FIFO and drain into idle W slots. Optional same-cycle bypass under WB_BYPASS_EN.
module wb_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        wwreg,
   input  logic        wm2reg,
   input  logic [4:0]  wrd,
   input  logic [31:0] wresult,
   input  logic [31:0] wdataout,
   input  logic        md_valid,
   input  logic [4:0]  md_rd,
   input  logic [31:0] md_result,
   output logic        md_ready,
   output logic        rf_we,
   output logic [4:0]  rf_wn,
   output logic [31:0] rf_d,
   output logic        mw_bubble,
   output logic [31:0] pend_mask,
   output logic [1:0]  fifo_cnt
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [4:0]  q_rd   [2];
   logic [31:0] q_data [2];
   logic [3:0]  starve_cnt;

   logic        wb_active;
   logic [31:0] wb_data;
   logic        fifo_empty;
   logic        bypass;
   logic        pop;
   logic        push;

   logic [4:0]  nxt_rd   [2];
   logic [31:0] nxt_data [2];
   logic [1:0]  nxt_cnt;
   logic [31:0] nxt_mask;

   assign wb_active  = wwreg & (wrd != 5'd0);
   assign wb_data    = wm2reg ? wdataout : wresult;
   assign fifo_empty = (fifo_cnt == 2'd0);
   assign md_ready   = (fifo_cnt < 2'd2) & ~clrn;

`ifdef WB_BYPASS_EN
   assign bypass = ~clrn & fifo_empty & ~wb_active & md_valid & (md_rd != 5'd0);
`else
   assign bypass = 1'b0;
`endif

   assign pop  = ~clrn & ~wb_active & ~fifo_empty;
   assign push = md_valid & md_ready & (md_rd != 5'd0) & ~bypass;

   assign mw_bubble = (starve_cnt == LIMIT);

   always_comb begin
      rf_we = 1'b0;
      rf_wn = 5'd0;
      rf_d  = 32'd0;
      if (!clrn) begin
         if (wb_active) begin
            rf_we = 1'b1;
            rf_wn = wrd;
            rf_d  = wb_data;
         end else if (!fifo_empty) begin
            rf_we = 1'b1;
            rf_wn = q_rd[0];
            rf_d  = q_data[0];
         end else if (bypass) begin
            rf_we = 1'b1;
            rf_wn = md_rd;
            rf_d  = md_result;
         end
      end
   end

   // Head lives in slot 0; a pop shifts slot 1 down before the push lands at the new tail.
   always_comb begin
      nxt_rd   = q_rd;
      nxt_data = q_data;
      nxt_cnt  = fifo_cnt;
      if (pop) begin
         nxt_rd[0]   = q_rd[1];
         nxt_data[0] = q_data[1];
         nxt_cnt     = fifo_cnt - 2'd1;
      end
      if (push) begin
         nxt_rd[nxt_cnt[0]]   = md_rd;
         nxt_data[nxt_cnt[0]] = md_result;
         nxt_cnt              = nxt_cnt + 2'd1;
      end
      nxt_mask = 32'd0;
      for (int i = 0; i < 2; i++) begin
         if (2'(i) < nxt_cnt) nxt_mask = nxt_mask | (32'd1 << nxt_rd[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (clrn) begin
         q_rd[0]    <= 5'd0;
         q_rd[1]    <= 5'd0;
         q_data[0]  <= 32'd0;
         q_data[1]  <= 32'd0;
         fifo_cnt   <= 2'd0;
         pend_mask  <= 32'd0;
         starve_cnt <= 4'd0;
      end else begin
         q_rd      <= nxt_rd;
         q_data    <= nxt_data;
         fifo_cnt  <= nxt_cnt;
         pend_mask <= nxt_mask;
         if (pop || fifo_empty) starve_cnt <= 4'd0;
         else if (wb_active && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_wb_port_arbiter;

   localparam int LIMIT = 4;

   logic        clk;
   logic        clrn;
   logic        wwreg;
   logic        wm2reg;
   logic [4:0]  wrd;
   logic [31:0] wresult;
   logic [31:0] wdataout;
   logic        md_valid;
   logic [4:0]  md_rd;
   logic [31:0] md_result;
   logic        md_ready;
   logic        rf_we;
   logic [4:0]  rf_wn;
   logic [31:0] rf_d;
   logic        mw_bubble;
   logic [31:0] pend_mask;
   logic [1:0]  fifo_cnt;

   wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .clrn(clrn), .wwreg(wwreg), .wm2reg(wm2reg), .wrd(wrd),
      .wresult(wresult), .wdataout(wdataout), .md_valid(md_valid), .md_rd(md_rd),
      .md_result(md_result), .md_ready(md_ready), .rf_we(rf_we), .rf_wn(rf_wn),
      .rf_d(rf_d), .mw_bubble(mw_bubble), .pend_mask(pend_mask), .fifo_cnt(fifo_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [4:0]  m_rd[$];
   logic [31:0] m_data[$];
   int          m_starve = 0;
   bit          m_valid = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs, compare every output with the model, then advance the model.
   task automatic step_begin(input bit rst, input bit ww, input bit m2r, input logic [4:0] rd,
                             input logic [31:0] res, input logic [31:0] dout, input bit mv,
                             input logic [4:0] mrd, input logic [31:0] mres);
      int          sz;
      bit          wbact, e_ready, e_byp, e_we, do_pop, do_push;
      logic [4:0]  e_wn;
      logic [31:0] e_d, e_mask;
      clrn = rst; wwreg = ww; wm2reg = m2r; wrd = rd; wresult = res; wdataout = dout;
      md_valid = mv; md_rd = mrd; md_result = mres;
      #1;
      sz      = m_rd.size();
      wbact   = ww && (rd != 5'd0);
      e_ready = (sz < 2) && !rst;
      e_byp   = 1'b0;
`ifdef WB_BYPASS_EN
      e_byp   = !rst && sz == 0 && !wbact && mv && mrd != 5'd0;
`endif
      e_we = 1'b0; e_wn = 5'd0; e_d = 32'd0;
      if (rst) e_we = 1'b0;
      else if (wbact) begin e_we = 1'b1; e_wn = rd; e_d = m2r ? dout : res; end
      else if (sz > 0) begin e_we = 1'b1; e_wn = m_rd[0]; e_d = m_data[0]; end
      else if (e_byp) begin e_we = 1'b1; e_wn = mrd; e_d = mres; end
      e_mask = 32'd0;
      for (int i = 0; i < sz; i++) e_mask = e_mask | (32'd1 << m_rd[i]);

      check("rf_we", {31'd0, rf_we}, {31'd0, e_we});
      if (e_we) begin
         check("rf_wn", {27'd0, rf_wn}, {27'd0, e_wn});
         check("rf_d", rf_d, e_d);
      end
      if (m_valid) begin
         check("md_ready", {31'd0, md_ready}, {31'd0, e_ready});
         check("fifo_cnt", {30'd0, fifo_cnt}, 32'(sz));
         check("pend_mask", pend_mask, e_mask);
         check("mw_bubble", {31'd0, mw_bubble}, {31'd0, m_starve == LIMIT});
      end else if (rst) begin
         check("md_ready_rst", {31'd0, md_ready}, 32'd0);
      end

      if (rst) begin
         m_rd.delete(); m_data.delete(); m_starve = 0; m_valid = 1;
      end else begin
         do_pop  = !wbact && sz > 0;
         do_push = mv && e_ready && mrd != 5'd0 && !e_byp;
         if (do_pop || sz == 0) m_starve = 0;
         else if (wbact && m_starve < LIMIT) m_starve++;
         if (do_pop) begin void'(m_rd.pop_front()); void'(m_data.pop_front()); end
         if (do_push) begin m_rd.push_back(mrd); m_data.push_back(mres); end
      end
   endtask

   task automatic step_end();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step_begin(0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0);
   endtask

   initial begin
      clrn = 1'b1; wwreg = 1'b0; wm2reg = 1'b0; wrd = 5'd0; wresult = 32'd0;
      wdataout = 32'd0; md_valid = 1'b0; md_rd = 5'd0; md_result = 32'd0;
      @(posedge clk);
      #1;

      // reset held with traffic present
      for (int i = 0; i < 2; i++) begin
         step_begin(1, 1, 0, 5'd5, 32'h11, 32'h22, 1, 5'd3, 32'h33);
         check("rst_we", {31'd0, rf_we}, 32'd0);
         check("rst_ready", {31'd0, md_ready}, 32'd0);
         step_end();
      end
      idle();
      check("rst_cnt", {30'd0, fifo_cnt}, 32'd0);
      check("rst_pend", pend_mask, 32'd0);
      step_end();

      // W priority over a concurrent mul/div push
      step_begin(0, 1, 1, 5'd5, 32'h1, 32'hDEADBEEF, 1, 5'd7, 32'h777);
      check("wp_wn", {27'd0, rf_wn}, 32'd5);
      check("wp_d", rf_d, 32'hDEADBEEF);
      step_end();
      idle();
      check("wp_cnt", {30'd0, fifo_cnt}, 32'd1);
      check("wp_pend", pend_mask, 32'h80);
      check("wp_drain_wn", {27'd0, rf_wn}, 32'd7);
      step_end();
      idle();
      check("wp_pend0", pend_mask, 32'd0);
      step_end();

      // fill FIFO while W is busy, then drain in order
      step_begin(0, 1, 0, 5'd10, 32'hA, 32'h0, 1, 5'd3, 32'h33);
      step_end();
      step_begin(0, 1, 0, 5'd10, 32'hA, 32'h0, 1, 5'd4, 32'h44);
      step_end();
      step_begin(0, 1, 0, 5'd10, 32'hA, 32'h0, 1, 5'd5, 32'h55);
      check("full_cnt", {30'd0, fifo_cnt}, 32'd2);
      check("full_ready", {31'd0, md_ready}, 32'd0);
      check("full_pend", pend_mask, 32'h18);
      step_end();
      idle();
      check("drain1_wn", {27'd0, rf_wn}, 32'd3);
      check("drain1_d", rf_d, 32'h33);
      step_end();
      idle();
      check("drain2_wn", {27'd0, rf_wn}, 32'd4);
      check("drain2_d", rf_d, 32'h44);
      step_end();
      idle();
      step_end();

      // starvation: one queued entry, W busy on r9 every cycle
      step_begin(0, 1, 0, 5'd9, 32'h9, 32'h0, 1, 5'd12, 32'hC);
      step_end();
      for (int i = 1; i <= 5; i++) begin
         step_begin(0, 1, 0, 5'd9, 32'h9, 32'h0, 0, 5'd0, 32'h0);
         check("starve_bubble", {31'd0, mw_bubble}, (i == 5) ? 32'd1 : 32'd0);
         step_end();
      end
      step_begin(0, 1, 0, 5'd9, 32'h9, 32'h0, 0, 5'd0, 32'h0);
      check("bubble_hold", {31'd0, mw_bubble}, 32'd1);
      step_end();
      idle();
      check("bubble_pop_wn", {27'd0, rf_wn}, 32'd12);
      step_end();
      idle();
      check("bubble_low", {31'd0, mw_bubble}, 32'd0);
      step_end();

      // r0: W write to r0 yields the slot; md_rd = 0 is swallowed
      step_begin(0, 1, 0, 5'd9, 32'h9, 32'h0, 1, 5'd2, 32'h22);
      step_end();
      step_begin(0, 1, 0, 5'd0, 32'hBAD, 32'h0, 1, 5'd0, 32'hBAD0);
      check("r0_wn", {27'd0, rf_wn}, 32'd2);
      check("r0_d", rf_d, 32'h22);
      check("r0_ready", {31'd0, md_ready}, 32'd1);
      step_end();
      idle();
      check("r0_cnt", {30'd0, fifo_cnt}, 32'd0);
      step_end();

      // empty FIFO, W idle, mul/div result offered
      step_begin(0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 5'd6, 32'h12345678);
`ifdef WB_BYPASS_EN
      check("byp_we", {31'd0, rf_we}, 32'd1);
      check("byp_wn", {27'd0, rf_wn}, 32'd6);
`else
      check("nobyp_we", {31'd0, rf_we}, 32'd0);
`endif
      step_end();
      idle();
`ifdef WB_BYPASS_EN
      check("byp_cnt", {30'd0, fifo_cnt}, 32'd0);
`else
      check("nobyp_cnt", {30'd0, fifo_cnt}, 32'd1);
      check("nobyp_d", rf_d, 32'h12345678);
`endif
      step_end();
      idle();
      step_end();

      // reset mid-operation discards queued results
      step_begin(0, 1, 0, 5'd8, 32'h8, 32'h0, 1, 5'd13, 32'hD);
      step_end();
      step_begin(1, 0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
      check("midrst_we", {31'd0, rf_we}, 32'd0);
      step_end();
      idle();
      check("midrst_cnt", {30'd0, fifo_cnt}, 32'd0);
      step_end();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         step_begin(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    $urandom, $urandom, $urandom_range(0, 2) != 0,
                    ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    $urandom);
         step_end();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter for the single register-file write port at the end of the 5-stage pipeline. Shares the port between the W stage, fed by the MEM/WB pipeline register, and a multi-cycle mul/div unit. W stage has fixed priority. Mul/div results wait in a 2-entry FIFO and drain into idle W slots; a starvation counter requests a pipeline bubble, and a pending-register mask lets the hazard unit interlock.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive blocked cycles before a bubble is requested; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  reset, synchronous, active-high; 1 at a rising edge clears all state.
- wwreg  in  1  W stage register-write enable.
- wm2reg  in  1  W stage select; 1 = memory data, 0 = ALU result.
- wrd  in  5  W stage destination register.
- wresult  in  32  W stage ALU result.
- wdataout  in  32  W stage memory load data.
- md_valid  in  1  mul/div result offered.
- md_rd  in  5  mul/div destination register.
- md_result  in  32  mul/div result.
- md_ready  out  1  arbiter can accept a mul/div result this cycle.
- rf_we  out  1  register-file write enable.
- rf_wn  out  5  register-file write address.
- rf_d  out  32  register-file write data.
- mw_bubble  out  1  request to hold upstream stages and load a bubble into MEM/WB.
- pend_mask  out  32  one-hot OR of destinations held in the FIFO.
- fifo_cnt  out  2  FIFO occupancy, 0..2.

## Operation
- wb_active = wwreg & (wrd != 0). Writes to r0 are never issued.
- W stage write data = wm2reg ? wdataout : wresult.
- When wb_active = 1:
  - rf_we = 1, rf_wn = wrd, rf_d = W stage write data.
  - No FIFO pop.
- When wb_active = 0 and fifo_cnt > 0:
  - rf_we = 1, rf_wn = head rd, rf_d = head data.
  - Head pops at the edge.
- Otherwise rf_we = 0, and rf_wn/rf_d are don't-care.
- md_ready = (fifo_cnt < 2) & ~clrn.
- Accept = md_valid & md_ready.
  - md_rd = 0: the result is accepted and discarded.
  - Otherwise the result is pushed at the tail.
- Push and pop in the same cycle: count is unchanged and order is preserved (FIFO, no reordering).
- pend_mask is registered and equals the OR of the one-hot rd of every valid entry after the edge. Bit 0 is always 0.
- WAW/RAW safety is the hazard unit's job, using pend_mask. The arbiter does no rd comparison.
- Starvation counter starve_cnt (4 bits):
  - Cleared on a pop or when fifo_cnt = 0.
  - Increments when fifo_cnt > 0 & wb_active.
  - Saturates at STARVE_LIMIT.
- mw_bubble = (starve_cnt == STARVE_LIMIT). It stays high until a pop happens.

## Timing
- Reset: fifo_cnt = 0, pend_mask = 0, starve_cnt = 0, mw_bubble = 0.
- While clrn = 1, rf_we = 0 and md_ready = 0.
- rf_we, rf_wn, rf_d and md_ready are combinational from current inputs and state. Timing is write-in-same-cycle for the W stage.
- Mul/div latency, accept to register-file write: minimum 1 cycle without bypass.
- Full FIFO (cnt = 2): md_ready = 0. A pop that cycle does not enable a push in the same cycle.
- Empty FIFO with W idle: rf_we = 0 unless bypass is compiled in.
- Bubble handshake: mw_bubble high in cycle N. The pipeline makes W idle in N+1, the head pops in N+1, and mw_bubble is low in N+2.
- Reset mid-operation: FIFO contents are discarded without being written. The mul/div unit must also be reset.

## Configuration
- WB_BYPASS_EN defined: when fifo_cnt = 0, wb_active = 0, md_valid = 1 and md_rd != 0:
  - The result is written the same cycle (rf_we = 1, rf_wn = md_rd, rf_d = md_result).
  - It is not enqueued; pend_mask and fifo_cnt are unchanged.
- WB_BYPASS_EN undefined: every accepted nonzero-rd result is enqueued, and the earliest write is the next cycle.

## Test plan
- Reset: hold clrn = 1 for 2 cycles with wwreg = 1 and md_valid = 1 → rf_we = 0, md_ready = 0. After release: fifo_cnt = 0, pend_mask = 0.
- W priority: wwreg = 1, wrd = 5, wm2reg = 1, wdataout = 0xDEADBEEF, plus a mul/div push of rd = 7 → rf writes r5 = 0xDEADBEEF, fifo_cnt = 1, pend_mask = 0x80. Next cycle, W idle → r7 written, pend_mask = 0.
- Full FIFO: push rd = 3 and rd = 4 while W is busy → fifo_cnt = 2, md_ready = 0, pend_mask = 0x18. W idle for 2 cycles → r3 then r4 written in order.
- Starvation: FIFO holds 1 entry, W busy (wrd = 9) every cycle, STARVE_LIMIT = 4 → mw_bubble rises in the 5th blocked cycle. Drive W idle next cycle → pop, then mw_bubble = 0.
- r0 handling: wwreg = 1 with wrd = 0 plus FIFO head rd = 2 → head r2 written. A mul/div push with md_rd = 0 is accepted and fifo_cnt does not change.
- Bypass (macro defined): empty FIFO, W idle, md_rd = 6, md_result = 0x12345678 → r6 written the same cycle, fifo_cnt stays 0. Macro undefined: the write happens the next cycle.
